// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage (master) and the fetch queue (slave).
interface fetch_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_instr;
    logic [ADDR_WIDTH-1:0] in_pcplus4;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pcplus4;
    logic [CNT_W-1:0]      count;

    modport master (
        output flush, in_valid, in_instr, in_pcplus4, out_ready,
        input  in_ready, out_valid, out_instr, out_pcplus4, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pcplus4, out_ready,
        output in_ready, out_valid, out_instr, out_pcplus4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Optional empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic empty_s;
    logic full_s;
    logic byp_s;
    logic push_s;
    logic pop_s;

    // Occupancy flags, handshake outputs and head-entry presentation.
    always_comb begin
        empty_s = (count_r == {CNT_W{1'b0}});
        full_s  = (count_r == CNT_W'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_s   = empty_s && q.in_valid && !q.flush && !rst;
`else
        byp_s   = 1'b0;
`endif
        q.in_ready  = !full_s;
        q.out_valid = (!empty_s && !q.flush) || byp_s;
        q.count     = count_r;
        if (!empty_s) begin
            q.out_instr   = instr_mem_r[rd_ptr_r];
            q.out_pcplus4 = pc_mem_r[rd_ptr_r];
        end else if (byp_s) begin
            q.out_instr   = q.in_instr;
            q.out_pcplus4 = q.in_pcplus4;
        end else begin
            q.out_instr   = {DATA_WIDTH{1'b0}};
            q.out_pcplus4 = {ADDR_WIDTH{1'b0}};
        end
        // A bypassed entry that decode takes immediately is never stored.
        push_s = q.in_valid && !full_s && !q.flush && !(byp_s && q.out_ready);
        pop_s  = !empty_s && !q.flush && q.out_ready;
    end

    // Pointer and occupancy state; flush clears it like a soft reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (q.flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents past the read pointer are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= q.in_instr;
            pc_mem_r[wr_ptr_r]    <= q.in_pcplus4;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
        end
    end
endmodule
